uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
// PURPOSE
//  UART receive deserializer: sibling stage to the transmitter on the far end of the serial line.
//  Oversamples serial_in on the shared 16x baud tick (enable) and recovers start/data/parity/stop.
//  Delivers one 11-bit record per character ({bi,fe,pe,data}) as a one-cycle push into the RX FIFO.
//  Uses the same LCR encoding as the transmitter.
// PARAMETERS
//  OSR          16  baud ticks per bit; even, >=4
//  SYNC_STAGES  2   serial_in synchronizer depth, >=2
// PORTS
//  clk         input   1   clock
//  reset       input   1   synchronous active-high reset
//  enable      input   1   baud tick; one clk wide, OSR per bit time
//  rx_reset    input   1   synchronous abort; return to IDLE, no push
//  lcr         input   8   [1:0] bits (00=5..11=8), [2] SB, [3] PE, [4] EP, [5] SP
//  serial_in   input   1   asynchronous RXD, idle high
//  rf_push     output  1   one-clk push strobe to RX FIFO
//  rf_data     output  11  [7:0] data (LSB-first, unused MSBs 0), [8] pe, [9] fe, [10] bi
//  rstate      output  3   FSM state code, for LSR/debug
// BEHAVIOUR
//  - Reset / rx_reset values: synchronizer flops=1, rstate=IDLE(0), counter=0, rf_push=0, rf_data=0.
//    rx_reset has priority over enable; a character already in progress is discarded.
//  - Sync input: rxd_s is serial_in delayed through SYNC_STAGES flops. FSM state, counter and
//    sampling advance only on clk cycles with enable=1. rf_push is independent of enable.
//  - States and codes:
//    IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, PUSH=5, WAIT_HIGH=6.
//  - IDLE: tick with rxd_s=0 -> START, cnt=0. lcr is latched at this point; a mid-frame lcr
//    write has no effect until the next character.
//  - Bit decisions:
//    START decides at cnt==OSR/2-1. Each later bit decides OSR ticks after the previous decision.
//  - START: decision=1 -> IDLE (false start, no push); decision=0 -> DATA.
//  - DATA: shift decisions in LSB-first, 5+lcr[1:0] bits. Then PARITY if PE=1, else STOP.
//  - PARITY: expected bit by {EP,SP}: 00 = ~^data (odd), 01 = 1, 10 = ^data (even), 11 = 0.
//    pe = decision != expected. pe=0 when PE=0.
//  - STOP: only the first stop bit is checked; SB is ignored on receive. fe = (decision==0).
//    bi = fe & data==0 & (parity bit==0 when PE=1). Then -> PUSH.
//  - PUSH: rf_push=1 for exactly one clk, on the clk after the stop-decision tick, with rf_data valid.
//    rf_data holds its value until the next push. Next state is WAIT_HIGH if fe, else IDLE.
//  - WAIT_HIGH: stay until a tick with rxd_s=1, then IDLE. A long break gives exactly one record.
//  - Back-to-back characters: start detection is allowed on the first tick after PUSH.
//    No idle gap is required beyond the stop-bit half.
//  - Widths: cnt is $clog2(OSR) bits and wraps only at decision points. bit counter is 3 bits.
// CONFIGURATION
//  UART_RX_MAJORITY_EN:
//    defined: each decision is the 2-of-3 majority of rxd_s on the decision tick and the two ticks
//    before it. The START decision point moves to cnt==OSR/2; bit spacing stays OSR.
//    A single-tick glitch at mid-bit is rejected.
//  undefined: each decision is the single rxd_s sample on the decision tick, with no majority storage.
// TESTING
//  1. OSR=16, lcr=0x03 (8N1), send 0xA5 -> one rf_push, rf_data=0x0A5, exactly 152 ticks + 1 clk after
//     the start edge reaches rxd_s.
//  2. lcr=0x1A (7E1), send 0x41 with parity bit 1 -> rf_data=0x141 (pe=1).
//     The same frame with correct parity -> 0x041.
//  3. lcr=0x00 (5N1), send 0x15 with stop=0, then line high -> rf_data=0x215 (fe=1).
//     The following frame is received normally.
//  4. Hold serial_in low for 40 bit times with 8N1 -> exactly one rf_data=0x600 (bi,fe).
//     No further push until the line returns high; the next frame 0x5A is received correctly.
//  5. 4-tick low pulse on an idle line -> no push, rstate returns to 0.
//     Assert rx_reset mid-DATA -> rstate=0, no push, and the next frame is correct.
//  6. UART_RX_MAJORITY_EN defined, 8N1, 0xFF with a 1-tick low glitch at mid-bit 3 -> rf_data=0x0FF.
//     With the macro undefined -> 0x0F7.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start/data/parity/stop recovery, one {bi,fe,pe,data} push per character.
// Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority bit decisions instead of a single sample.
module uart_rx_deserializer #(
   parameter int unsigned OSR         = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        rx_reset,
   input  logic [7:0]  lcr,
   input  logic        serial_in,
   output logic        rf_push,
   output logic [10:0] rf_data,
   output logic [2:0]  rstate
);

   localparam int unsigned CW = $clog2(OSR);
   localparam logic [CW-1:0] FULL = CW'(OSR - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [CW-1:0] START_PT = CW'(OSR / 2);
`else
   localparam logic [CW-1:0] START_PT = CW'(OSR / 2 - 1);
`endif

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      PUSH      = 3'd5,
      WAIT_HIGH = 3'd6
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             data_q, data_d;
   logic                   par_q, par_d;
   logic [1:0]             wl_q, wl_d;
   logic                   pen_q, pen_d, ep_q, ep_d, sp_q, sp_d;
   logic                   push_q, push_d;
   logic [10:0]            rec_q, rec_d;
   logic                   rxd_s, decision, decide, exp_par, pe, fe, bi;
   logic [2:0]             last_bit;
   logic                   unused_lcr;

   assign rxd_s      = sync_q[SYNC_STAGES-1];
   assign unused_lcr = ^{lcr[7:6], lcr[2]};

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q;
   assign decision = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);
`else
   assign decision = rxd_s;
`endif

   assign decide   = enable && (cnt_q == ((state_q == START) ? START_PT : FULL));
   assign last_bit = 3'd4 + {1'b0, wl_q};
   always_comb begin
      unique case ({ep_q, sp_q})
         2'b00:   exp_par = ~^data_q;
         2'b01:   exp_par = 1'b1;
         2'b10:   exp_par = ^data_q;
         default: exp_par = 1'b0;
      endcase
   end
   assign pe = pen_q & (par_q != exp_par);
   assign fe = ~decision;
   assign bi = fe & (data_q == 8'h00) & (~pen_q | ~par_q);

   always_ff @(posedge clk) begin
      if (reset || rx_reset) begin
         sync_q  <= '1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         wl_q    <= '0;
         pen_q   <= 1'b0;
         ep_q    <= 1'b0;
         sp_q    <= 1'b0;
         push_q  <= 1'b0;
         rec_q   <= '0;
`ifdef UART_RX_MAJORITY_EN
         hist_q  <= '1;
`endif
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], serial_in};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         par_q   <= par_d;
         wl_q    <= wl_d;
         pen_q   <= pen_d;
         ep_q    <= ep_d;
         sp_q    <= sp_d;
         push_q  <= push_d;
         rec_q   <= rec_d;
`ifdef UART_RX_MAJORITY_EN
         if (enable) hist_q <= {hist_q[0], rxd_s};
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      data_d  = data_q;
      par_d   = par_q;
      wl_d    = wl_q;
      pen_d   = pen_q;
      ep_d    = ep_q;
      sp_d    = sp_q;
      push_d  = 1'b0;
      rec_d   = rec_q;
      // The counter only wraps at a decision, so each bit decides OSR ticks after the previous one.
      if (enable && (state_q inside {START, DATA, PARITY, STOP}))
         cnt_d = decide ? '0 : cnt_q + 1'b1;
      unique case (state_q)
         IDLE: if (enable && !rxd_s) begin
            state_d = START;
            cnt_d   = '0;
            bit_d   = '0;
            data_d  = '0;
            par_d   = 1'b0;
            wl_d    = lcr[1:0];
            pen_d   = lcr[3];
            ep_d    = lcr[4];
            sp_d    = lcr[5];
         end
         START: if (decide) state_d = decision ? IDLE : DATA;
         DATA: if (decide) begin
            data_d[bit_q] = decision;
            if (bit_q == last_bit) state_d = pen_q ? PARITY : STOP;
            else                   bit_d   = bit_q + 3'd1;
         end
         PARITY: if (decide) begin
            par_d   = decision;
            state_d = STOP;
         end
         STOP: if (decide) begin
            rec_d   = {bi, fe, pe, data_q};
            push_d  = 1'b1;
            state_d = PUSH;
         end
         PUSH:      state_d = rec_q[9] ? WAIT_HIGH : IDLE;
         WAIT_HIGH: if (enable && rxd_s) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   assign rf_push = push_q;
   assign rf_data = rec_q;
   assign rstate  = state_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames driven tick-aligned, expected records queued and
// compared on each rf_push. Build with +define+UART_RX_MAJORITY_EN to cover the majority variant.
module tb_uart_rx_deserializer;
   localparam int unsigned OSR = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        rx_reset = 1'b0;
   logic [7:0]  lcr = 8'h03;
   logic        serial_in = 1'b1;
   logic        rf_push;
   logic [10:0] rf_data;
   logic [2:0]  rstate;

   int          total = 0;
   int          pass_cnt = 0;
   int          fail_cnt = 0;
   int          tk = 0;
   int          n_push = 0;
   int          last_push_tk = -1;
   logic        prev_push = 1'b0;
   logic        div = 1'b0;
   logic [10:0] sb[$];

   uart_rx_deserializer #(.OSR(OSR), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .rx_reset(rx_reset), .lcr(lcr),
      .serial_in(serial_in), .rf_push(rf_push), .rf_data(rf_data), .rstate(rstate)
   );

   always #5 clk = ~clk;

   // Baud tick on every second clock.
   always @(negedge clk) begin
      div = ~div;
      enable = div;
   end

   always @(posedge clk) if (enable) tk <= tk + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rf_push === 1'b1) begin
         n_push++;
         last_push_tk = tk;
         check("push_one_clk", {31'd0, prev_push}, 32'd0);
         if (sb.size() == 0) check("unexpected_push", {21'd0, rf_data}, 32'h7ff);
         else                check("rf_data", {21'd0, rf_data}, {21'd0, sb.pop_front()});
      end
      prev_push = rf_push;
   end

   // Holds serial_in for n ticks; returns 1 time unit after the last tick edge.
   task automatic drive(input logic v, input int n);
      serial_in = v;
      repeat (n) begin
         do @(posedge clk); while (enable !== 1'b1);
      end
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit pbit,
                             input bit stopv);
      drive(1'b0, OSR);
      for (int i = 0; i < nb; i++) drive(d[i], OSR);
      if (pen) drive(pbit, OSR);
      drive(stopv, OSR);
   endtask

   task automatic drain(input string tag);
      int i = 0;
      while (sb.size() != 0 && i < 400) begin
         @(posedge clk);
         i++;
      end
      check(tag, sb.size(), 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, np;
      repeat (4) @(posedge clk);
      #1;
      check("reset_rstate", {29'd0, rstate}, 32'd0);
      check("reset_push", {31'd0, rf_push}, 32'd0);
      check("reset_data", {21'd0, rf_data}, 32'd0);
      reset = 1'b0;
      drive(1'b1, 4);

      // 8N1 0xA5 with push latency measured from the detect tick.
      lcr = 8'h03;
      sb.push_back(11'h0A5);
      k = tk;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
`ifdef UART_RX_MAJORITY_EN
      check("latency_8n1", last_push_tk, k + 2 + 153);
`else
      check("latency_8n1", last_push_tk, k + 2 + 152);
`endif

      // 7E1 back-to-back: wrong parity then correct parity.
      lcr = 8'h1A;
      sb.push_back(11'h141);
      send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
      sb.push_back(11'h041);
      send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
      drain("drain_7e1");

      // 5N1 framing error, then a normal frame.
      lcr = 8'h00;
      sb.push_back(11'h215);
      send_frame(8'h15, 5, 1'b0, 1'b0, 1'b0);
      check("fe_wait_high", {29'd0, rstate}, 32'd6);
      drive(1'b1, 2 * OSR);
      check("fe_idle", {29'd0, rstate}, 32'd0);
      sb.push_back(11'h00A);
      send_frame(8'h0A, 5, 1'b0, 1'b0, 1'b1);
      drain("drain_5n1");

      // Long break yields one record only.
      lcr = 8'h03;
      np = n_push;
      sb.push_back(11'h600);
      drive(1'b0, 40 * OSR);
      check("break_wait_high", {29'd0, rstate}, 32'd6);
      check("break_one_push", n_push - np, 1);
      drive(1'b1, 2 * OSR);
      check("break_idle", {29'd0, rstate}, 32'd0);
      sb.push_back(11'h05A);
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
      drain("drain_break");

      // False start from a short low pulse.
      np = n_push;
      drive(1'b0, 4);
      drive(1'b1, 2 * OSR);
      check("false_start_rstate", {29'd0, rstate}, 32'd0);
      check("false_start_nopush", n_push - np, 0);

      // rx_reset in the middle of DATA.
      drive(1'b0, OSR);
      drive(1'b1, 3 * OSR);
      check("mid_data_rstate", {29'd0, rstate}, 32'd2);
      rx_reset = 1'b1;
      @(posedge clk);
      #1;
      rx_reset = 1'b0;
      check("rx_reset_rstate", {29'd0, rstate}, 32'd0);
      drive(1'b1, 8 * OSR);
      check("rx_reset_nopush", n_push - np, 0);
      sb.push_back(11'h0C3);
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
      drain("drain_rx_reset");

      // 0xFF with a one-tick low glitch at the bit-3 decision tick.
`ifdef UART_RX_MAJORITY_EN
      sb.push_back(11'h0FF);
`else
      sb.push_back(11'h0F7);
`endif
      drive(1'b0, OSR);
      drive(1'b1, 3 * OSR + OSR / 2);
      drive(1'b0, 1);
      drive(1'b1, OSR / 2 - 1 + 4 * OSR + OSR);
      drain("drain_glitch");
      drive(1'b1, OSR);
      check("final_rstate", {29'd0, rstate}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
